// File: rtl/xge_tx_pkg.sv
// Shared constants and types for the XGMII TX link-fault sequencer.
// Holds XGMII control codes, the fault-mode enum and the fixed
// replacement words driven toward the PHY while the MAC is muted.
package xge_tx_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;
  localparam logic [7:0] LF_CODE     = 8'h01;
  localparam logic [7:0] RF_CODE     = 8'h02;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    SEND_RF   = 2'd1,
    SEND_IDLE = 2'd2
  } tx_fault_mode_t;

  // Sequence ordered set in both column halves: 0x9C in lanes 0/4,
  // fault code in lanes 3/7, zero in between.
  function automatic logic [63:0] seq_ordered_set(input logic [7:0] code);
    return {code, 8'h00, 8'h00, XGMII_SEQ, code, 8'h00, 8'h00, XGMII_SEQ};
  endfunction

  localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_CTRL = 8'hFF;
  localparam logic [7:0]  SEQ_CTRL  = 8'h11;

endpackage

// File: rtl/xgmii_tx_frame_tracker.sv
// Frame-boundary tracker for the 64-bit XGMII TX word stream.
// Ports:
//   clk, rst       : TX clock, synchronous active-high reset
//   txd, txc       : MAC word being presented this cycle
//   start, term    : this word carries a start (lane 0/4) / a terminate (any lane)
//   in_frame_prev  : frame-open flag before this word is accounted for
module xgmii_tx_frame_tracker
  import xge_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output logic        start,
  output logic        term,
  output logic        in_frame_prev
);

  logic [7:0] lane_term;
  logic       start_l0;
  logic       start_l4;
  logic       term_after_start;
  logic       in_frame_d;
  logic       in_frame_q;

  always_comb begin
    lane_term = '0;
    for (int i = 0; i < 8; i++) begin
      lane_term[i] = txc[i] && (txd[8*i +: 8] == XGMII_TERM);
    end
  end

  assign start_l0 = txc[0] && (txd[7:0]   == XGMII_START);
  assign start_l4 = txc[4] && (txd[39:32] == XGMII_START);
  assign start    = start_l0 | start_l4;
  assign term     = |lane_term;

  // Only a terminate after the start closes the new frame; a terminate
  // before a lane-4 start belongs to the previous frame.
  assign term_after_start = start_l4 ? |lane_term[7:5] : |lane_term[7:1];

  always_comb begin
    in_frame_d = in_frame_q;
    if (start && !term_after_start) begin
      in_frame_d = 1'b1;
    end else if (term) begin
      in_frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_q <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
    end
  end

  assign in_frame_prev = in_frame_q;

endmodule

// File: rtl/xge_tx_fault_ctrl.sv
// TX link-fault sequencer between the MAC dequeue stage and the XGMII TX pins.
// Replaces MAC output with Remote Fault ordered sets or Idles while a fault
// or disable is present; switches only at frame boundaries.
// Ports:
//   clk_xgmii_tx, reset_xgmii_tx : TX clock, synchronous active-high reset
//   txd_in, txc_in               : MAC word
//   ctrl_tx_enable_ctx           : transmit enable
//   status_local_fault_ctx       : local fault
//   status_remote_fault_ctx      : remote fault
//   xgmii_txd, xgmii_txc         : registered word to the PHY
//   status_tx_mode               : 0 NORMAL, 1 SEND_RF, 2 SEND_IDLE
//   stat_tx_frame_dropped        : one pulse per discarded frame start
//
// state     | meaning
// ----------+----------------------------------------------
// NORMAL    | MAC words passed through unchanged
// SEND_RF   | Remote Fault ordered sets sent, MAC discarded
// SEND_IDLE | Idles sent, MAC discarded
module xge_tx_fault_ctrl
  import xge_tx_pkg::*;
#(
  parameter int CLEAR_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx,
  input  logic [63:0] txd_in,
  input  logic [7:0]  txc_in,
  input  logic        ctrl_tx_enable_ctx,
  input  logic        status_local_fault_ctx,
  input  logic        status_remote_fault_ctx,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  status_tx_mode,
  output logic        stat_tx_frame_dropped
);

  localparam logic [CNT_W-1:0] CLEAR_MAX = CNT_W'(CLEAR_CYCLES);

  tx_fault_mode_t   state_q, state_d;
  tx_fault_mode_t   target;
  logic [CNT_W-1:0] clean_cnt_q, clean_cnt_d;
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;
  logic             drop_q, drop_d;
  logic             start;
  logic             in_frame_prev;
  logic             clean_done;
  // Terminate is already folded into in_frame inside the tracker.
  logic             trk_term_unused;

  xgmii_tx_frame_tracker u_tracker (
    .clk           (clk_xgmii_tx),
    .rst           (reset_xgmii_tx),
    .txd           (txd_in),
    .txc           (txc_in),
    .start         (start),
    .term          (trk_term_unused),
    .in_frame_prev (in_frame_prev)
  );

  always_comb begin
    target = NORMAL;
    if (status_local_fault_ctx) begin
      target = SEND_RF;
    end else if (status_remote_fault_ctx || !ctrl_tx_enable_ctx) begin
      target = SEND_IDLE;
    end
  end

  always_comb begin
    clean_cnt_d = '0;
    if (target == NORMAL) begin
      clean_cnt_d = (clean_cnt_q == CLEAR_MAX) ? clean_cnt_q : clean_cnt_q + CNT_W'(1);
    end
  end

  // Counts the current cycle, so the return can happen on this very word.
  assign clean_done = (clean_cnt_d == CLEAR_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if (target != NORMAL && !in_frame_prev && !start) begin
          state_d = target;
        end
      end
      SEND_RF, SEND_IDLE: begin
        if (clean_done && !in_frame_prev) begin
          state_d = NORMAL;
        end else if (target != NORMAL) begin
          state_d = target;
        end
      end
      default: state_d = SEND_IDLE;
    endcase
  end

  // The word that causes a transition already gets the new state's output.
  always_comb begin
    txd_d = IDLE_WORD;
    txc_d = IDLE_CTRL;
    case (state_d)
      NORMAL: begin
        txd_d = txd_in;
        txc_d = txc_in;
      end
      SEND_RF: begin
        txd_d = seq_ordered_set(RF_CODE);
        txc_d = SEQ_CTRL;
      end
      default: begin
        txd_d = IDLE_WORD;
        txc_d = IDLE_CTRL;
      end
    endcase
    drop_d = start && (state_d != NORMAL);
  end

  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      state_q     <= SEND_IDLE;
      clean_cnt_q <= '0;
      txd_q       <= IDLE_WORD;
      txc_q       <= IDLE_CTRL;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clean_cnt_q <= clean_cnt_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      drop_q      <= drop_d;
    end
  end

  assign xgmii_txd             = txd_q;
  assign xgmii_txc             = txc_q;
  assign status_tx_mode        = state_q;
  assign stat_tx_frame_dropped = drop_q;

endmodule

// File: tb/tb_xge_tx_fault_ctrl.sv
module tb_xge_tx_fault_ctrl;

  localparam logic [63:0] ID = 64'h0707070707070707;
  localparam logic [7:0]  IC = 8'hFF;
  localparam logic [63:0] RD = 64'h0200009C0200009C;
  localparam logic [7:0]  RC = 8'h11;
  localparam logic [63:0] SW = 64'hD5555555555555FB;  // start in lane 0
  localparam logic [7:0]  SC = 8'h01;
  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'h99AABBCCDDEEFF00;
  localparam logic [63:0] TW = 64'h07070707FDCCBBAA;  // term in lane 3
  localparam logic [7:0]  TC = 8'hF8;
  localparam logic [63:0] XW = 64'h555555FB07FDBBAA;  // term lane 2, start lane 4
  localparam logic [7:0]  XC = 8'h1C;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic [1:0]  m;
    logic        drop;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] txd_in;
  logic [7:0]  txc_in;
  logic        en, lf, rf;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [1:0]  status_tx_mode;
  logic        stat_tx_frame_dropped;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  xge_tx_fault_ctrl #(.CLEAR_CYCLES(4), .CNT_W(8)) dut (
    .clk_xgmii_tx            (clk),
    .reset_xgmii_tx          (rst),
    .txd_in                  (txd_in),
    .txc_in                  (txc_in),
    .ctrl_tx_enable_ctx      (en),
    .status_local_fault_ctx  (lf),
    .status_remote_fault_ctx (rf),
    .xgmii_txd               (xgmii_txd),
    .xgmii_txc               (xgmii_txc),
    .status_tx_mode          (status_tx_mode),
    .stat_tx_frame_dropped   (stat_tx_frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic vec(input logic r, input logic e, input logic l, input logic f,
                     input logic [63:0] d, input logic [7:0] c,
                     input logic [63:0] ed, input logic [7:0] ec,
                     input logic [1:0] em, input logic edrop);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; lf = l; rf = f; txd_in = d; txc_in = c;
    x.d = ed; x.c = ec; x.m = em; x.drop = edrop;
    q.push_back(x);
  endtask

  task automatic pass(input logic l, input logic f, input logic [63:0] d, input logic [7:0] c);
    vec(1'b0, 1'b1, l, f, d, c, d, c, 2'd0, 1'b0);
  endtask

  task automatic idle_out(input logic l, input logic f, input logic [63:0] d,
                          input logic [7:0] c, input logic drop);
    vec(1'b0, 1'b1, l, f, d, c, ID, IC, 2'd2, drop);
  endtask

  task automatic rf_out(input logic l, input logic f, input logic [63:0] d, input logic [7:0] c);
    vec(1'b0, 1'b1, l, f, d, c, RD, RC, 2'd1, 1'b0);
  endtask

  // Monitor: one output word per cycle, compared against the queue head.
  initial begin
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (xgmii_txd !== e.d || xgmii_txc !== e.c ||
            status_tx_mode !== e.m || stat_tx_frame_dropped !== e.drop) begin
          n_miss++;
          $display("FAIL vec%0d: got txd=%h txc=%h mode=%0d drop=%b, want txd=%h txc=%h mode=%0d drop=%b",
                   idx, xgmii_txd, xgmii_txc, status_tx_mode, stat_tx_frame_dropped,
                   e.d, e.c, e.m, e.drop);
        end
        idx++;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; lf = 1'b0; rf = 1'b0; txd_in = ID; txc_in = IC;

    // Reset state
    vec(1'b1, 1'b1, 1'b0, 1'b0, ID, IC, ID, IC, 2'd2, 1'b0);
    vec(1'b1, 1'b1, 1'b0, 1'b0, D1, 8'h00, ID, IC, 2'd2, 1'b0);

    // 1: clean count 1..3 idle, 4th word returns to NORMAL, then pass-through
    idle_out(0, 0, ID, IC, 0);
    idle_out(0, 0, ID, IC, 0);
    idle_out(0, 0, ID, IC, 0);
    pass(0, 0, ID, IC);
    pass(0, 0, SW, SC);
    pass(0, 0, D1, 8'h00);
    pass(0, 0, D2, 8'h00);
    pass(0, 0, TW, TC);

    // Disable between frames -> Idle immediately, re-enable needs 4 clean cycles
    vec(1'b0, 1'b0, 1'b0, 1'b0, ID, IC, ID, IC, 2'd2, 1'b0);
    idle_out(0, 0, ID, IC, 0);
    idle_out(0, 0, ID, IC, 0);
    idle_out(0, 0, ID, IC, 0);
    pass(0, 0, ID, IC);

    // 2: local fault at 3rd word of 6-word frame; frame completes, then RF
    pass(0, 0, SW, SC);
    pass(0, 0, D1, 8'h00);
    pass(1, 0, D2, 8'h00);
    pass(1, 0, D1, 8'h00);
    pass(1, 0, D2, 8'h00);
    pass(1, 0, TW, TC);
    rf_out(1, 0, ID, IC);

    // 3: remote fault held, three frames dropped
    idle_out(0, 1, ID, IC, 0);
    for (int k = 0; k < 3; k++) begin
      idle_out(0, 1, SW, SC, 1);
      idle_out(0, 1, D1, 8'h00, 0);
      idle_out(0, 1, TW, TC, 0);
      idle_out(0, 1, ID, IC, 0);
    end

    // 4: both faults -> RF; drop local -> Idle on that word
    rf_out(1, 1, ID, IC);
    rf_out(1, 1, ID, IC);
    idle_out(0, 1, ID, IC, 0);

    // 5: fault clears inside a discarded frame; return waits for its term
    idle_out(0, 1, SW, SC, 1);
    idle_out(0, 1, D1, 8'h00, 0);
    idle_out(0, 0, D2, 8'h00, 0);
    idle_out(0, 0, D1, 8'h00, 0);
    idle_out(0, 0, D2, 8'h00, 0);
    idle_out(0, 0, TW, TC, 0);
    pass(0, 0, SW, SC);
    pass(0, 0, D1, 8'h00);
    pass(0, 0, TW, TC);

    // 6: term lane 2 + start lane 4 keeps the frame open, fault cannot switch
    pass(0, 0, SW, SC);
    pass(0, 0, D1, 8'h00);
    pass(1, 0, XW, XC);
    pass(1, 0, D2, 8'h00);

    // Reset mid-frame
    vec(1'b1, 1'b1, 1'b0, 1'b0, D1, 8'h00, ID, IC, 2'd2, 1'b0);
    @(posedge clk);
    #2;
    n_vec++;
    if (dut.u_tracker.in_frame_q !== 1'b0) begin
      n_miss++;
      $display("FAIL in_frame_after_reset: got %b want 0", dut.u_tracker.in_frame_q);
    end
    idle_out(0, 0, D2, 8'h00, 0);
    idle_out(0, 0, TW, TC, 0);
    idle_out(0, 0, ID, IC, 0);
    pass(0, 0, ID, IC);
    pass(0, 0, SW, SC);
    pass(0, 0, D1, 8'h00);
    pass(0, 0, TW, TC);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected words left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
